// File: rtl/sail_bp_pkg.sv
// Shared encodings and next-state helper for the 2-bit saturating branch counters.
package sail_bp_pkg;

    localparam logic [1:0] BP_STRONG_NT = 2'b00;
    localparam logic [1:0] BP_WEAK_NT   = 2'b01;
    localparam logic [1:0] BP_WEAK_T    = 2'b10;
    localparam logic [1:0] BP_STRONG_T  = 2'b11;

    function automatic logic [1:0] bp_sat_next(input logic [1:0] state, input logic taken);
        logic [1:0] next_s;
        case (state)
            BP_STRONG_NT: next_s = taken ? BP_WEAK_NT  : BP_STRONG_NT;
            BP_WEAK_NT:   next_s = taken ? BP_WEAK_T   : BP_STRONG_NT;
            BP_WEAK_T:    next_s = taken ? BP_STRONG_T : BP_WEAK_NT;
            BP_STRONG_T:  next_s = taken ? BP_STRONG_T : BP_WEAK_T;
            default:      next_s = BP_WEAK_NT;
        endcase
        return next_s;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// One 2-bit saturating predictor entry; trains only when enabled.
module bp_sat_counter
    import sail_bp_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       taken,
    output logic [1:0] state
);

    logic [1:0] state_r;

    // Entry state: reset to weak not-taken, otherwise step toward the resolved direction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= BP_WEAK_NT;
        end else if (en) begin
            state_r <= bp_sat_next(state_r, taken);
        end else begin
            state_r <= state_r;
        end
    end

    assign state = state_r;

endmodule

// File: rtl/branch_history_predictor.sv
// Direct-mapped 2-bit-counter branch predictor with zero-latency lookup, mistake
// detection for the downstream mistake register, and saturating statistics.
module branch_history_predictor
    import sail_bp_pkg::*;
#(
    parameter int IDX_BITS = 4,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             branch_decode_sig,
    input  logic [31:0]      fetch_pc,
    output logic             prediction,
    input  logic             branch_mem_sig,
    input  logic [31:0]      mem_pc,
    input  logic             actual_branch_decision,
    input  logic             prediction_mem,
    output logic             mistake,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [IDX_BITS-1:0] fetch_idx_s;
    logic [IDX_BITS-1:0] mem_idx_s;
    logic [1:0]          entry_s [ENTRIES];
    logic [CNT_W-1:0]    branch_count_r;
    logic [CNT_W-1:0]    mispredict_count_r;
    logic                unused_pc_bits_s;

    assign fetch_idx_s = fetch_pc[IDX_BITS+1:2];
    assign mem_idx_s   = mem_pc[IDX_BITS+1:2];
    assign unused_pc_bits_s = ^{fetch_pc[31:IDX_BITS+2], fetch_pc[1:0],
                                mem_pc[31:IDX_BITS+2], mem_pc[1:0]};

    // Only the entry addressed by the resolving branch trains; aliases share it.
    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        bp_sat_counter u_cnt (
            .clk   (clk),
            .reset (reset),
            .en    (branch_mem_sig && (mem_idx_s == IDX_BITS'(g))),
            .taken (actual_branch_decision),
            .state (entry_s[g])
        );
    end

    // Lookup reads the registered entry, so a same-cycle update is seen next cycle.
    assign prediction = branch_decode_sig & entry_s[fetch_idx_s][1];
    assign mistake    = branch_mem_sig & (prediction_mem ^ actual_branch_decision);

    // Statistics counters saturate at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count_r     <= '0;
            mispredict_count_r <= '0;
        end else begin
            if (branch_mem_sig && (branch_count_r != {CNT_W{1'b1}})) begin
                branch_count_r <= branch_count_r + CNT_W'(1);
            end else begin
                branch_count_r <= branch_count_r;
            end
            if (mistake && (mispredict_count_r != {CNT_W{1'b1}})) begin
                mispredict_count_r <= mispredict_count_r + CNT_W'(1);
            end else begin
                mispredict_count_r <= mispredict_count_r;
            end
        end
    end

    assign branch_count     = branch_count_r;
    assign mispredict_count = mispredict_count_r;

endmodule

// File: tb/tb_branch_history_predictor.sv
// Directed plus randomized bench comparing two predictor instances (32-bit and 4-bit
// statistics) against an integer-arithmetic reference model.
module tb_branch_history_predictor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        branch_decode_sig = 1'b0;
    logic [31:0] fetch_pc = 32'd0;
    logic        branch_mem_sig = 1'b0;
    logic [31:0] mem_pc = 32'd0;
    logic        actual_branch_decision = 1'b0;
    logic        prediction_mem = 1'b0;
    logic        prediction, prediction4;
    logic        mistake, mistake4;
    logic [31:0] branch_count, mispredict_count;
    logic [3:0]  branch_count4, mispredict_count4;

    int          checks = 0;
    int          errors = 0;
    int          model_tab [16];
    longint      model_br = 0;
    longint      model_mp = 0;

    always #5 clk = ~clk;

    branch_history_predictor #(.IDX_BITS(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .branch_decode_sig(branch_decode_sig), .fetch_pc(fetch_pc),
        .prediction(prediction), .branch_mem_sig(branch_mem_sig), .mem_pc(mem_pc),
        .actual_branch_decision(actual_branch_decision), .prediction_mem(prediction_mem),
        .mistake(mistake), .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    branch_history_predictor #(.IDX_BITS(4), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .branch_decode_sig(branch_decode_sig), .fetch_pc(fetch_pc),
        .prediction(prediction4), .branch_mem_sig(branch_mem_sig), .mem_pc(mem_pc),
        .actual_branch_decision(actual_branch_decision), .prediction_mem(prediction_mem),
        .mistake(mistake4), .branch_count(branch_count4), .mispredict_count(mispredict_count4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v, input longint maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic drive(input logic rst, input logic bd, input logic [31:0] fpc,
                         input logic bm, input logic [31:0] mpc, input logic act, input logic pm);
        reset = rst; branch_decode_sig = bd; fetch_pc = fpc;
        branch_mem_sig = bm; mem_pc = mpc; actual_branch_decision = act; prediction_mem = pm;
    endtask

    // Check combinational outputs, clock once, advance the model, then check statistics.
    task automatic tick(input bit check_comb);
        logic exp_pred, exp_mis;
        int   idx;
        #1;
        exp_pred = branch_decode_sig && (model_tab[fetch_pc[5:2]] >= 2);
        exp_mis  = branch_mem_sig && (prediction_mem != actual_branch_decision);
        if (check_comb) begin
            chk("prediction", {31'd0, prediction}, {31'd0, exp_pred});
            chk("prediction4", {31'd0, prediction4}, {31'd0, exp_pred});
            chk("mistake", {31'd0, mistake}, {31'd0, exp_mis});
        end
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 16; i++) model_tab[i] = 1;
            model_br = 0;
            model_mp = 0;
        end else if (branch_mem_sig) begin
            idx = int'(mem_pc[5:2]);
            if (actual_branch_decision) model_tab[idx] = (model_tab[idx] < 3) ? model_tab[idx] + 1 : 3;
            else                        model_tab[idx] = (model_tab[idx] > 0) ? model_tab[idx] - 1 : 0;
            model_br++;
            if (exp_mis) model_mp++;
        end
        #1;
        chk("branch_count", branch_count, 32'(sat(model_br, 64'hFFFF_FFFF)));
        chk("mispredict_count", mispredict_count, 32'(sat(model_mp, 64'hFFFF_FFFF)));
        chk("branch_count4", {28'd0, branch_count4}, 32'(sat(model_br, 15)));
        chk("mispredict_count4", {28'd0, mispredict_count4}, 32'(sat(model_mp, 15)));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model_tab[i] = 1;

        // 1: reset, then every index predicts not-taken
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        tick(1'b0);
        chk("reset_bcnt", branch_count, 32'd0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 32'(i * 4), 1'b0, $urandom, 1'($urandom), 1'($urandom));
            tick(1'b1);
            chk("init_pred", {31'd0, prediction}, 32'd0);
        end

        // 2: train index 4 taken, then saturate and back off once
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h10, 1'b1, 1'b1);
        tick(1'b1);
        drive(1'b0, 1'b1, 32'h10, 1'b0, 32'd0, 1'b0, 1'b0);
        tick(1'b1);
        chk("taken_once_pred", {31'd0, prediction}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h10, 1'b1, 1'b1);
            tick(1'b1);
        end
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h10, 1'b0, 1'b1);
        tick(1'b1);
        drive(1'b0, 1'b1, 32'h10, 1'b0, 32'd0, 1'b0, 1'b0);
        tick(1'b1);
        chk("after_nt_pred", {31'd0, prediction}, 32'd1);

        // 3: alias through index 4, neighbour untouched
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h50, 1'b1, 1'b1);
        tick(1'b1);
        drive(1'b0, 1'b1, 32'h10, 1'b0, 32'd0, 1'b0, 1'b0);
        tick(1'b1);
        drive(1'b0, 1'b1, 32'h14, 1'b0, 32'd0, 1'b0, 1'b0);
        tick(1'b1);
        chk("neighbour_pred", {31'd0, prediction}, 32'd0);

        // 4: mispredict counted; same pattern with branch_mem_sig low ignored
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h30, 1'b1, 1'b0);
        #1 chk("mistake_hi", {31'd0, mistake}, 32'd1);
        tick(1'b1);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'h30, 1'b1, 1'b0);
        #1 chk("mistake_gated", {31'd0, mistake}, 32'd0);
        tick(1'b1);

        // 5: same-cycle read/write collision, no bypass
        drive(1'b0, 1'b1, 32'h20, 1'b1, 32'h20, 1'b1, 1'b1);
        #1 chk("collide_pre", {31'd0, prediction}, 32'd0);
        tick(1'b1);
        drive(1'b0, 1'b1, 32'h20, 1'b0, 32'd0, 1'b0, 1'b0);
        #1 chk("collide_post", {31'd0, prediction}, 32'd1);
        tick(1'b1);

        // 6: reset dominates an update, then statistics saturation
        drive(1'b1, 1'b0, 32'd0, 1'b1, 32'h20, 1'b1, 1'b0);
        tick(1'b0);
        chk("reset_dom_bcnt", branch_count, 32'd0);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h24, 1'b1, 1'b1);
        tick(1'b1);
        drive(1'b0, 1'b1, 32'h20, 1'b0, 32'd0, 1'b0, 1'b0);
        tick(1'b1);
        chk("reset_dom_pred", {31'd0, prediction}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h3C, 1'($urandom), 1'($urandom));
            tick(1'b1);
        end
        chk("sat4_bcnt", {28'd0, branch_count4}, 32'd15);
        chk("wide_bcnt", branch_count, 32'd21);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(63) == 0), 1'($urandom), $urandom,
                  1'($urandom), $urandom, 1'($urandom), 1'($urandom));
            tick(1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
